// File: rtl/sa_tile_scheduler_pkg.sv
// Shared types and sizing for the systolic-array tile scheduler.
package sa_sched_pkg;
    localparam int D_W       = 8;
    localparam int SA_R      = 16;
    localparam int SA_C      = 16;
    localparam int MAX_TM    = 8;
    localparam int MAX_TN    = 8;
    localparam int TIMEOUT_C = 1024;

    localparam int TM_W = $clog2(MAX_TM + 1);
    localparam int TN_W = $clog2(MAX_TN + 1);
    localparam int TO_W = $clog2(TIMEOUT_C + 1);

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_CLR   = 6'b000010,
        S_START = 6'b000100,
        S_WAIT  = 6'b001000,
        S_WB    = 6'b010000,
        S_DONE  = 6'b100000
    } state_e;

    // A command is legal only when both tile counts lie in 1..MAX.
    function automatic logic cmd_legal(input logic [TM_W-1:0] tm, input logic [TN_W-1:0] tn);
        return (tm != '0) && (tn != '0) && (tm <= TM_W'(MAX_TM)) && (tn <= TN_W'(MAX_TN));
    endfunction
endpackage

// File: rtl/sa_tile_scheduler_if.sv
// Command, SA-control and writeback signals between the scheduler and its neighbours.
interface sa_tile_scheduler_if;
    import sa_sched_pkg::*;

    logic            cmd_vld;
    logic            cmd_rdy;
    logic [TM_W-1:0] cmd_tm;
    logic [TN_W-1:0] cmd_tn;
    logic            sa_clr_n;
    logic            sa_start;
    logic            sa_out_vld;
    logic [TM_W-1:0] tile_r;
    logic [TN_W-1:0] tile_c;
    logic            wb_vld;
    logic            wb_rdy;
    logic            busy;
    logic            done;
    logic            err;

    modport slave (
        input  cmd_vld, cmd_tm, cmd_tn, sa_out_vld, wb_rdy,
        output cmd_rdy, sa_clr_n, sa_start, tile_r, tile_c, wb_vld, busy, done, err
    );

    modport master (
        output cmd_vld, cmd_tm, cmd_tn, sa_out_vld, wb_rdy,
        input  cmd_rdy, sa_clr_n, sa_start, tile_r, tile_c, wb_vld, busy, done, err
    );
endinterface

// File: rtl/sa_tile_scheduler_idx_cnt.sv
// Row-major 2-D tile index counter: C runs fastest, wrapping into R.
module sa_tile_idx_cnt
    import sa_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sync_rst_n,
    input  logic            clr,
    input  logic            inc,
    input  logic [TM_W-1:0] tm,
    input  logic [TN_W-1:0] tn,
    output logic [TM_W-1:0] r,
    output logic [TN_W-1:0] c,
    output logic            last
);
    assign last = (r == tm - TM_W'(1)) && (c == tn - TN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
            c <= '0;
        end else if (!sync_rst_n || clr) begin
            r <= '0;
            c <= '0;
        end else if (inc) begin
            if (c == tn - TN_W'(1)) begin
                c <= '0;
                r <= r + TM_W'(1);
            end else begin
                c <= c + TN_W'(1);
            end
        end
    end
endmodule

// File: rtl/sa_tile_scheduler.sv
// Tile sequencer for the systolic-array wrapper: clear, start, wait, writeback per tile.
// Optional SA_SCHED_TIMEOUT_EN adds a watchdog on the wait for SA results.
module sa_tile_scheduler
    import sa_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync_rst_n,
    sa_tile_scheduler_if.slave   bus
);
    state_e          state, state_nxt;
    logic [TM_W-1:0] tm_q;
    logic [TN_W-1:0] tn_q;
    logic [TM_W-1:0] r;
    logic [TN_W-1:0] c;
    logic            last;
    logic            accept_ok, accept_bad, cnt_inc, to_hit;

`ifdef SA_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state == S_WAIT) && !bus.sa_out_vld && (to_cnt == TO_W'(TIMEOUT_C - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        to_cnt <= '0;
        else if (!sync_rst_n)                              to_cnt <= '0;
        else if (state == S_WAIT && state_nxt == S_WAIT)   to_cnt <= to_cnt + TO_W'(1);
        else                                               to_cnt <= '0;
    end
`else
    assign to_hit = 1'b0;
`endif

    sa_tile_idx_cnt u_idx (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_rst_n (sync_rst_n),
        .clr        (accept_ok),
        .inc        (cnt_inc),
        .tm         (tm_q),
        .tn         (tn_q),
        .r          (r),
        .c          (c),
        .last       (last)
    );

    assign bus.tile_r = r;
    assign bus.tile_c = c;

    always_comb begin
        state_nxt  = state;
        accept_ok  = 1'b0;
        accept_bad = 1'b0;
        cnt_inc    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.cmd_vld) begin
                    accept_ok  = cmd_legal(bus.cmd_tm, bus.cmd_tn);
                    accept_bad = !accept_ok;
                    if (accept_ok) state_nxt = S_CLR;
                end
            end
            S_CLR:   state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.sa_out_vld) state_nxt = S_WB;
                else if (to_hit)    state_nxt = S_IDLE;
            end
            S_WB: begin
                if (bus.wb_rdy) begin
                    cnt_inc   = !last;
                    state_nxt = last ? S_DONE : S_CLR;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            bus.cmd_rdy  <= 1'b1;
            bus.sa_clr_n <= 1'b0;
            bus.sa_start <= 1'b0;
            bus.wb_vld   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            tm_q         <= '0;
            tn_q         <= '0;
        end else if (!sync_rst_n) begin
            state        <= S_IDLE;
            bus.cmd_rdy  <= 1'b1;
            bus.sa_clr_n <= 1'b0;
            bus.sa_start <= 1'b0;
            bus.wb_vld   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            tm_q         <= '0;
            tn_q         <= '0;
        end else begin
            state        <= state_nxt;
            bus.cmd_rdy  <= (state_nxt == S_IDLE);
            bus.sa_clr_n <= state_nxt inside {S_START, S_WAIT, S_WB};
            bus.sa_start <= (state_nxt == S_START);
            bus.wb_vld   <= (state_nxt == S_WB);
            bus.busy     <= (state_nxt != S_IDLE);
            bus.done     <= (state_nxt == S_DONE);
            if (accept_ok) begin
                tm_q    <= bus.cmd_tm;
                tn_q    <= bus.cmd_tn;
                bus.err <= 1'b0;
            end else if (accept_bad || to_hit) begin
                bus.err <= 1'b1;
            end
        end
    end
endmodule
